// File: rtl/demux_rr_sched.sv
// Round-robin grant controller driving the sel/din inputs of demux1to8.
// Define DEMUX_SCHED_GAP_EN to insert one dead GAP cycle after every grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant active; arbitrate from ptr each cycle
// S_GRANT | channel sel owns the demux for DWELL cycles, din follows src
// S_GAP   | one dead cycle between owners (DEMUX_SCHED_GAP_EN only)
module demux_rr_sched #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       src,
    output logic [2:0] sel,
    output logic       din,
    output logic [7:0] grant,
    output logic       busy,
    output logic       done
);

`ifdef DEMUX_SCHED_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1} state_t;
`endif

    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    state_t        state, state_nx;
    logic [2:0]    ptr, ptr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    sel_nx;
    logic [7:0]    grant_nx;

    logic [2:0]    arb_base;
    logic          win_found;
    logic [2:0]    win_idx;
    logic          tc;

    // First requester found scanning upward from base, modulo 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] idx;
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign tc = (cnt == '0);

    // At the end of a grant the search must already start after the served channel.
    assign arb_base = (state == S_GRANT) ? sel + 3'd1 : ptr;
    assign {win_found, win_idx} = rr_pick(req, arb_base);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= 3'd0;
            cnt   <= '0;
            sel   <= 3'd0;
            grant <= 8'd0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            sel   <= sel_nx;
            grant <= grant_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        sel_nx   = sel;
        grant_nx = grant;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nx = S_GRANT;
                    sel_nx   = win_idx;
                    grant_nx = 8'd1 << win_idx;
                    cnt_nx   = CNT_LOAD;
                end
            end
            S_GRANT: begin
                if (tc) begin
                    ptr_nx = sel + 3'd1;
`ifdef DEMUX_SCHED_GAP_EN
                    state_nx = S_GAP;
                    grant_nx = 8'd0;
`else
                    if (win_found) begin
                        sel_nx   = win_idx;
                        grant_nx = 8'd1 << win_idx;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                        grant_nx = 8'd0;
                    end
`endif
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
`ifdef DEMUX_SCHED_GAP_EN
            S_GAP: begin
                if (win_found) begin
                    state_nx = S_GRANT;
                    sel_nx   = win_idx;
                    grant_nx = 8'd1 << win_idx;
                    cnt_nx   = CNT_LOAD;
                end else begin
                    state_nx = S_IDLE;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
                grant_nx = 8'd0;
            end
        endcase
    end

`ifdef DEMUX_SCHED_GAP_EN
    assign busy = (state == S_GRANT) || (state == S_GAP);
`else
    assign busy = (state == S_GRANT);
`endif
    assign done = (state == S_GRANT) && tc;
    assign din  = src & (state == S_GRANT);

endmodule

// File: tb/tb_demux_rr_sched.sv
// Randomized scoreboard bench for demux_rr_sched against an owner/remaining-cycles model.
module tb_demux_rr_sched;

    localparam int DWELL = 4;
`ifdef DEMUX_SCHED_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'hFF;
    logic       src = 1'b1;
    logic [2:0] sel;
    logic       din;
    logic [7:0] grant;
    logic       busy;
    logic       done;

    demux_rr_sched #(.DWELL(DWELL), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .src(src),
        .sel(sel), .din(din), .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] grant;
        logic       busy;
        logic       done;
        logic       din;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    // model: who owns the demux, how many cycles it still has, where the next search starts
    int   m_owner = -1;
    int   m_left = 0;
    int   m_ptr = 0;
    int   m_sel = 0;
    bit   m_gap = 1'b0;

    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 0; k < 8; k++)
            if (r[(base + k) % 8]) return (base + k) % 8;
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [7:0] r);
        int w;
        if (!rst) begin
            m_owner = -1; m_left = 0; m_ptr = 0; m_sel = 0; m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ptr = (m_owner + 1) % 8;
                if (GAP) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    w = pick(r, m_ptr);
                    m_owner = w;
                    if (w >= 0) begin m_sel = w; m_left = DWELL; end
                end
            end
        end else begin
            m_gap = 1'b0;
            w = pick(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_sel = w; m_left = DWELL; end
        end
    endtask

    // one clock cycle: account for the edge, then apply inputs for the new cycle
    task automatic cycle(input logic r, input logic [7:0] q, input logic s);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge(rst_n, req);
        rst_n = r;
        req   = q;
        src   = s;
        e.sel   = 3'(m_sel);
        e.grant = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.busy  = (m_owner >= 0) || m_gap;
        e.done  = (m_owner >= 0) && (m_left == 1);
        e.din   = (m_owner >= 0) && s;
        exp_q.push_back(e);
    endtask

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sel",   {5'd0, sel},  {5'd0, e.sel});
            chk("grant", grant,        e.grant);
            chk("busy",  {7'd0, busy}, {7'd0, e.busy});
            chk("done",  {7'd0, done}, {7'd0, e.done});
            chk("din",   {7'd0, din},  {7'd0, e.din});
            if (done) done_seen++;
        end
    end

    initial begin
        logic [7:0] rq;
        // reset held two edges with everything requesting
        cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b1, 8'h20, 1'b1);
        // single request on channel 5, one cycle
        cycle(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'h00, 1'($urandom));
        // full contention from ptr=0
        cycle(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 36; i++) cycle(1'b1, 8'hFF, 1'($urandom));
        // fairness between channels 0 and 7
        cycle(1'b0, 8'h81, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h81, 1'($urandom));
        // non-preemption: channel 3 drops its request immediately
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h08, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h00, 1'(i % 2));
        // reset in the second grant cycle
        cycle(1'b1, 8'h04, 1'b1);
        cycle(1'b1, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00, 1'b1);
        // two adjacent requesters (gap between owners when GAP is built in)
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'h03, 1'b1);
        // random traffic, occasional reset
        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: rq = 8'h00;
                    1: rq = 8'd1 << $urandom_range(0, 7);
                    2: rq = 8'($urandom) & 8'($urandom);
                    default: rq = 8'($urandom);
                endcase
            end
            cycle(($urandom_range(0, 99) != 0), rq, 1'($urandom));
        end
        cycle(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        total++;
        if (done_seen == 0) begin
            bad++;
            $display("FAIL done_activity: got %0d pulses expected >0", done_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
